// File: rtl/multfu_buffered.sv
// Iterative shift-add multiplier feeding a small result queue that is drained by CDB and ROB grants.
// Optional macro MULTFU_SIGNED_EN enables the signed high/low result modes.
module multfu_buffered #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ROBW   = 4,
    parameter int unsigned QDEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       input_transmit,
    input  logic [7:0]                 operand,
    input  logic [1:0][WIDTH-1:0]      depvals,
    input  logic [7:0]                 wbs,
    input  logic [7:0]                 flags,
    input  logic [ROBW-1:0]            robid,
    input  logic                       cdb_transmit,
    output logic                       cdb_transmit_out,
    output logic [ROBW-1:0]            cdb_id,
    output logic [WIDTH-1:0]           cdb_val,
    input  logic                       rob_transmit,
    output logic                       rob_transmit_out,
    output logic [ROBW-1:0]            robid_out,
    output logic [7:0]                 flags_out,
    output logic [7:0]                 wbs_out,
    output logic [WIDTH-1:0]           value_out,
    output logic                       busy
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned EW = ROBW + 16 + WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, PUSH} state_t;

    state_t               state_q, state_d;
    logic                 accept, step_en, push_en, pop, empty, full;
    logic [WIDTH-1:0]     a_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [CW-1:0]        cnt_q;
    logic                 hi_sel_q;
    logic [7:0]           wbs_q, flags_q;
    logic [ROBW-1:0]      robid_q;
    logic [WIDTH:0]       sum_c;
    logic [WIDTH-1:0]     hi_c, result_c;

    logic [EW-1:0]        q_mem [QDEPTH];
    logic [EW-1:0]        head_c;
    logic [PW-1:0]        head_q, tail_q;
    logic [PW:0]          count_q;
    logic                 cdb_done_q, rob_done_q, cdb_fin, rob_fin;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (input_transmit) state_d = MUL;
            MUL:     if (cnt_q == CW'(WIDTH - 1)) state_d = PUSH;
            PUSH:    if (!full || pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        accept  = 1'b0;
        step_en = 1'b0;
        push_en = 1'b0;
        case (state_q)
            IDLE: accept = input_transmit;
            MUL: begin
                busy    = 1'b1;
                step_en = 1'b1;
            end
            PUSH: begin
                busy    = 1'b1;
                push_en = !full || pop;
            end
            default: ;
        endcase
    end

    // One multiplier bit per step: add multiplicand to the upper half, then shift right.
    assign sum_c = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : WIDTH'(0))};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            hi_sel_q <= 1'b0;
            wbs_q    <= '0;
            flags_q  <= '0;
            robid_q  <= '0;
        end else if (accept) begin
            a_q      <= depvals[0];
            prod_q   <= {WIDTH'(0), depvals[1]};
            cnt_q    <= '0;
            hi_sel_q <= operand[0];
            wbs_q    <= wbs;
            flags_q  <= flags;
            robid_q  <= robid;
        end else if (step_en) begin
            prod_q <= {sum_c, prod_q[WIDTH-1:1]};
            cnt_q  <= cnt_q + CW'(1);
        end
    end

`ifdef MULTFU_SIGNED_EN
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic             unused_op;
    assign unused_op = ^operand[7:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q   <= '0;
            sgn_q <= 1'b0;
        end else if (accept) begin
            b_q   <= depvals[1];
            sgn_q <= operand[1];
        end
    end

    // Two's-complement fix-up of the unsigned high half; the low half is sign-agnostic.
    always_comb begin
        hi_c = prod_q[2*WIDTH-1:WIDTH];
        if (sgn_q) begin
            if (a_q[WIDTH-1]) hi_c = hi_c - b_q;
            if (b_q[WIDTH-1]) hi_c = hi_c - a_q;
        end
    end
`else
    logic unused_op;
    assign unused_op = ^operand[7:1];
    assign hi_c      = prod_q[2*WIDTH-1:WIDTH];
`endif

    assign result_c = hi_sel_q ? hi_c : prod_q[WIDTH-1:0];

    assign empty            = (count_q == '0);
    assign full             = (count_q == (PW+1)'(QDEPTH));
    assign cdb_transmit_out = !empty && !cdb_done_q;
    assign rob_transmit_out = !empty && !rob_done_q;
    assign cdb_fin          = cdb_done_q || (cdb_transmit_out && cdb_transmit);
    assign rob_fin          = rob_done_q || (rob_transmit_out && rob_transmit);
    assign pop              = !empty && cdb_fin && rob_fin;

    assign head_c = empty ? '0 : q_mem[head_q];
    assign {robid_out, wbs_out, flags_out, value_out} = head_c;
    assign cdb_id  = robid_out;
    assign cdb_val = value_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            cdb_done_q <= 1'b0;
            rob_done_q <= 1'b0;
            for (int unsigned i = 0; i < QDEPTH; i++) q_mem[i] <= '0;
        end else begin
            if (push_en) begin
                q_mem[tail_q] <= {robid_q, wbs_q, flags_q, result_c};
                tail_q        <= (tail_q == PW'(QDEPTH - 1)) ? '0 : tail_q + PW'(1);
            end
            if (pop) head_q <= (head_q == PW'(QDEPTH - 1)) ? '0 : head_q + PW'(1);
            case ({push_en, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: ;
            endcase
            // Delivery marks track the head entry only and restart with each new head.
            if (pop) begin
                cdb_done_q <= 1'b0;
                rob_done_q <= 1'b0;
            end else begin
                if (cdb_transmit_out && cdb_transmit) cdb_done_q <= 1'b1;
                if (rob_transmit_out && rob_transmit) rob_done_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/multfu_buffered.md
MULTFU_BUFFERED -- requirements
Module: multfu_buffered

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits.
REQ-002 SHALL have parameter ROBW, default 4, meaning ROB id width.
REQ-003 SHALL have parameter QDEPTH, default 2, meaning result-queue entries (power of two, >=2).
REQ-004 SHALL have ports clk in 1, the single clock; rst in 1, reset, synchronous and active-high.
REQ-005 SHALL have input_transmit in 1 (issue valid), operand in 8 (mode select), depvals in [1:0][WIDTH-1:0] (multiplicands), wbs in 8 (writeback tag), flags in 8, robid in ROBW.
REQ-006 SHALL have cdb_transmit in 1 (CDB grant), cdb_transmit_out out 1 (CDB request), cdb_id out ROBW, cdb_val out WIDTH.
REQ-007 SHALL have rob_transmit in 1 (ROB grant), rob_transmit_out out 1 (ROB request), robid_out out ROBW, flags_out out 8, wbs_out out 8, value_out out WIDTH.
REQ-008 SHALL have busy out 1, high when no new issue can be accepted.

Function
REQ-009 SHALL implement FSM states IDLE, MUL, PUSH; busy = (state != IDLE).
REQ-010 SHALL accept an issue at an edge where input_transmit=1 and state=IDLE, latching depvals, operand[1:0], wbs, flags, robid, moving to MUL; input_transmit while busy is ignored.
REQ-011 SHALL compute in MUL one shift-add step per cycle, exactly WIDTH cycles, forming the full 2*WIDTH-bit product, then move to PUSH.
REQ-012 SHALL select result by operand[1:0]: 00 low half unsigned, 01 high half unsigned, 10 low half signed, 11 high half signed.
REQ-013 SHALL in PUSH write {robid, wbs, flags, value} to the queue tail and return to IDLE at that edge if the queue is not full or the head pops at the same edge; otherwise stay in PUSH.
REQ-014 SHALL give latency: with empty queue, requests assert in the cycle after edge WIDTH+1 following the accept edge (accept edge = edge 0).
REQ-015 SHALL drive cdb_transmit_out = head valid and not yet CDB-delivered; rob_transmit_out = head valid and not yet ROB-delivered.
REQ-016 SHALL drive cdb_id/robid_out, cdb_val/value_out, wbs_out, flags_out from the queue head; all zero when the queue is empty.
REQ-017 SHALL mark CDB delivered at an edge with cdb_transmit_out=1 and cdb_transmit=1, and likewise for ROB with rob_transmit.
REQ-018 SHALL pop the head at the edge where both deliveries are complete, including both grants at the same edge or the second grant after the first; delivered marks clear on pop.
REQ-019 SHALL keep head outputs stable while either request is pending; grants with no pending request are ignored.
REQ-020 SHALL wrap queue pointers modulo QDEPTH and keep an occupancy count 0..QDEPTH; flags_out equals the issued flags unchanged.

Reset
REQ-021 SHALL on rst=1 at an edge set state IDLE, empty the queue, clear delivered marks and datapath registers; all outputs 0.
REQ-022 SHALL discard any in-flight multiply or undelivered result when reset asserts mid-operation; no request asserts until a fresh issue completes.

Configuration
REQ-023 SHALL honour macro MULTFU_SIGNED_EN: defined, modes 10/11 are signed two's-complement per REQ-012; undefined, operand[1] is ignored, all operations unsigned, no sign-correction logic built.

Verification
REQ-024 SHALL test WIDTH=8, mode 00, depvals {5,10}, robid 1, wbs B1 -> after WIDTH+1 edges both requests high, value 50, cdb_id 1, wbs_out B1.
REQ-025 SHALL test mode 01, {200,200} -> value 156 (40000>>8); mode 00 same operands -> value 64.
REQ-026 SHALL test with MULTFU_SIGNED_EN, mode 11, {-3 (FD), 5} -> value FF; mode 10 -> F1; without the macro mode 11 -> value 04.
REQ-027 SHALL test split grants: cdb_transmit at cycle k, rob_transmit held low until k+3 -> cdb_transmit_out drops after k, head held, pop only after ROB grant.
REQ-028 SHALL test back-pressure: grants held low, issue QDEPTH+1 ops -> queue fills, FSM stalls in PUSH with busy=1; single dual grant -> stalled result pushed at the same edge, results delivered in issue order.
REQ-029 SHALL test rst asserted mid-MUL with one queued result -> next cycle all outputs 0, busy 0, queued result never delivered.
